// File: rtl/dmem_arbiter.sv
// Arbitrates single-port dmem between the MEM-stage core port and a debug/loader port.
// Optional round-robin contention policy is enabled by defining DMEM_ARB_RR_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_funct3,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_DBG} rd_owner_t;

    rd_owner_t  rd_owner;
    logic [7:0] wait_cnt;
    logic       starve;
    logic       core_gnt;
    logic       dbg_win;

`ifdef DMEM_ARB_RR_EN
    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_DBG  = 1'b1;
    logic last_owner;
`endif

    assign starve = (wait_cnt == 8'(MAX_WAIT));

    // Grant decision; everything is held off while reset is asserted.
    always_comb begin
        core_gnt = 1'b0;
        dbg_win  = 1'b0;
        if (reset) begin
`ifdef DMEM_ARB_RR_EN
            if (core_req && dbg_req) begin
                if (starve || last_owner == OWNER_CORE) dbg_win  = 1'b1;
                else                                     core_gnt = 1'b1;
            end else begin
                core_gnt = core_req;
                dbg_win  = dbg_req;
            end
`else
            dbg_win  = dbg_req & (~core_req | starve);
            core_gnt = core_req & ~dbg_win;
`endif
        end
    end

    always_comb begin
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_funct3 = 3'b000;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (core_gnt) begin
            mem_we     = core_we;
            mem_re     = ~core_we;
            mem_funct3 = core_funct3;
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
        end else if (dbg_win) begin
            mem_we     = dbg_we;
            mem_re     = ~dbg_we;
            mem_funct3 = 3'b010;
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
        end
    end

    assign core_stall  = reset & core_req & ~core_gnt;
    assign dbg_gnt     = dbg_win;
    assign core_rvalid = (rd_owner == RD_CORE);
    assign dbg_rvalid  = (rd_owner == RD_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : 32'd0;
    assign dbg_rdata   = dbg_rvalid  ? mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner <= RD_NONE;
            wait_cnt <= 8'd0;
`ifdef DMEM_ARB_RR_EN
            last_owner <= OWNER_CORE;
`endif
        end else begin
            if (core_gnt && !core_we)     rd_owner <= RD_CORE;
            else if (dbg_win && !dbg_we)  rd_owner <= RD_DBG;
            else                          rd_owner <= RD_NONE;

            if (!dbg_req || dbg_win)      wait_cnt <= 8'd0;
            else if (!starve)             wait_cnt <= wait_cnt + 8'd1;
`ifdef DMEM_ARB_RR_EN
            if (core_gnt)                 last_owner <= OWNER_CORE;
            else if (dbg_win)             last_owner <= OWNER_DBG;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural one-cycle-latency dmem.
module tb_dmem_arbiter;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_req, core_we;
    logic [2:0]        core_funct3;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic              core_stall, core_rvalid;
    logic [31:0]       core_rdata;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_gnt, dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              mem_we, mem_re;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; core_funct3 = 3'b010; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 0;
        idle();
        repeat (2) step();
        core_req = 1; core_addr = 10'h010;
        @(negedge clk);
        checks++;
        if ({core_stall, dbg_gnt, mem_re, mem_we, core_rvalid, dbg_rvalid} !== 6'b0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_outputs: stall=%b gnt=%b re=%b we=%b rv=%b/%b addr=%h required all 0",
                     core_stall, dbg_gnt, mem_re, mem_we, core_rvalid, dbg_rvalid, mem_addr);
        end
        step();
        reset = 1;
        @(negedge clk);
        checks++;
        if (mem_re !== 1'b1 || core_stall !== 1'b0 || core_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: re=%b stall=%b rvalid=%b required 1 0 0", mem_re, core_stall, core_rvalid);
        end
        step();
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL reset_first_load: rvalid=%b data=%h required 1 deadbeef", core_rvalid, core_rdata);
        end
        // read still granted; reset drops mid-cycle so it must not return data
        @(negedge clk);
        reset = 0;
        step();
        checks++;
        if (core_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_kills_read: rvalid=%b/%b required 0/0", core_rvalid, dbg_rvalid);
        end
        reset = 1;
        idle();
        step();
    endtask

    task automatic test_core_load();
        core_req = 1; core_we = 0; core_addr = 10'h010;
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 10'h010 || core_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL load_issue: stall=%b re=%b addr=%h rvalid=%b required 0 1 010 0",
                     core_stall, mem_re, mem_addr, core_rvalid);
        end
        step();
        idle();
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF || dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL load_data: rvalid=%b data=%h dbg_rvalid=%b required 1 deadbeef 0",
                     core_rvalid, core_rdata, dbg_rvalid);
        end
        step();
        checks++;
        if (core_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL load_single_rvalid: rvalid=%b required 0", core_rvalid);
        end
    endtask

    task automatic test_starve();
        core_req = 1; core_we = 0; core_addr = 10'h000;
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'h030;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            checks++;
            if (dbg_gnt !== (i == 9) || core_stall !== (i == 9)) begin
                failures++;
                $display("FAIL starve_cycle%0d: dbg_gnt=%b stall=%b required %b %b",
                         i, dbg_gnt, core_stall, (i == 9), (i == 9));
            end
            if (i == 9) begin
                checks++;
                if (mem_addr !== 10'h030 || mem_funct3 !== 3'b010 || mem_re !== 1'b1) begin
                    failures++;
                    $display("FAIL starve_mem: addr=%h f3=%b re=%b required 030 010 1", mem_addr, mem_funct3, mem_re);
                end
            end
            step();
        end
        // dbg keeps requesting: its wait count must have restarted from zero
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hA5A5_0030 || core_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL starve_rdata: dbg_rvalid=%b data=%h core_rvalid=%b required 1 a5a50030 0",
                     dbg_rvalid, dbg_rdata, core_rvalid);
        end
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b0 || core_stall !== 1'b0) begin
            failures++;
            $display("FAIL starve_cleared: dbg_gnt=%b stall=%b required 0 0", dbg_gnt, core_stall);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_write_then_read();
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h020; dbg_wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wdata !== 32'h12345678) begin
            failures++;
            $display("FAIL dbg_write: gnt=%b we=%b re=%b wdata=%h required 1 1 0 12345678",
                     dbg_gnt, mem_we, mem_re, mem_wdata);
        end
        step();
        idle();
        core_req = 1; core_addr = 10'h020;
        step();
        idle();
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 32'h12345678 || dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL raw_read: rvalid=%b data=%h dbg_rvalid=%b required 1 12345678 0",
                     core_rvalid, core_rdata, dbg_rvalid);
        end
        step();
    endtask

    task automatic test_alternate();
        logic [31:0] vals [4] = '{32'h1111_0040, 32'h2222_0041, 32'h3333_0042, 32'h4444_0043};
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                logic pc;
                pc = ((i - 1) % 2 == 0);
                checks++;
                if (core_rvalid !== pc || dbg_rvalid !== !pc ||
                    (pc ? core_rdata : dbg_rdata) !== vals[i-1] || (pc ? dbg_rdata : core_rdata) !== 32'd0) begin
                    failures++;
                    $display("FAIL alternate%0d: rvalid=%b/%b rdata=%h/%h required %b/%b data %h",
                             i - 1, core_rvalid, dbg_rvalid, core_rdata, dbg_rdata, pc, !pc, vals[i-1]);
                end
            end
            idle();
            if (i < 4) begin
                core_req = (i % 2 == 0); core_addr = 10'(10'h040 + i);
                dbg_req  = (i % 2 == 1); dbg_addr  = 10'(10'h040 + i);
            end
            step();
        end
        checks++;
        if (core_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL alternate_tail: rvalid=%b/%b required 0/0", core_rvalid, dbg_rvalid);
        end
    endtask

`ifdef DMEM_ARB_RR_EN
    task automatic test_contention();
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h050; dbg_wdata = 32'h0;
        step();
        idle();
        core_req = 1; core_addr = 10'h000;
        dbg_req = 1; dbg_addr = 10'h001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (dbg_gnt !== (i % 2 == 1) || core_stall !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL rr_cycle%0d: dbg_gnt=%b stall=%b required %b %b",
                         i, dbg_gnt, core_stall, (i % 2 == 1), (i % 2 == 1));
            end
            step();
        end
        idle();
        step();
    endtask
`else
    task automatic test_contention();
        core_req = 1; core_addr = 10'h000;
        dbg_req = 1; dbg_addr = 10'h001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (dbg_gnt !== 1'b0 || core_stall !== 1'b0 || mem_addr !== 10'h000) begin
                failures++;
                $display("FAIL prio_cycle%0d: dbg_gnt=%b stall=%b addr=%h required 0 0 000",
                         i, dbg_gnt, core_stall, mem_addr);
            end
            step();
        end
        idle();
        step();
    endtask
`endif

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 32'hA5A5_0000 | 32'(a);
        mem[10'h010] = 32'hDEADBEEF;
        mem[10'h040] = 32'h1111_0040;
        mem[10'h041] = 32'h2222_0041;
        mem[10'h042] = 32'h3333_0042;
        mem[10'h043] = 32'h4444_0043;
        mem_rdata = 32'd0;
        test_reset();
        test_core_load();
`ifndef DMEM_ARB_RR_EN
        test_starve();
`endif
        test_write_then_read();
        test_alternate();
        test_contention();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
